// File: rtl/l2_pmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_pmem_responder_pkg
// Description : Shared LC-3b memory types for the L2 physical-memory responder:
//               word/line types, line index type, FSM state encoding and the
//               byte-offset width of a 16-byte line.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_pmem_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;
  typedef logic [11:0]  lc3b_pmem_index;

  // Address bits [3:0] select a byte within a 16-byte line.
  localparam int LC3B_LINE_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEMAND   = 3'd1,
    S_PREFETCH = 3'd2,
    S_DRESP    = 3'd3,
    S_NRESP    = 3'd4
  } lc3b_pmem_state_t;

endpackage
`default_nettype wire

// File: rtl/l2_pmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : l2_pmem_responder_if
// Description : L2 <-> physical memory bus. Demand port (read/write) and
//               next-line prefetch port (read only), both line granular.
//   master : L2 side   - drives requests, receives resp pulses and lines
//   slave  : memory    - receives requests, drives resp pulses and lines
// Revision    : 1.0 - initial release
// ============================================================================
interface l2_pmem_responder_if;
  import l2_pmem_responder_pkg::*;

  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_address;
  lc3b_data pmem_wdata;
  logic     pmem_resp;
  lc3b_data pmem_rdata;
  logic     pmem_n_read;
  lc3b_word pmem_n_address;
  logic     pmem_n_resp;
  lc3b_data pmem_n_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_n_read, pmem_n_address,
    input  pmem_resp, pmem_rdata, pmem_n_resp, pmem_n_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_n_read, pmem_n_address,
    output pmem_resp, pmem_rdata, pmem_n_resp, pmem_n_rdata
  );

endinterface
`default_nettype wire

// File: rtl/pmem_line_array.sv
`default_nettype none
// ============================================================================
// Module      : pmem_line_array
// Description : Synchronous single-port LINES x 128-bit line store.
//   clk   in  clock
//   we    in  write enable: wdata is stored at index
//   re    in  read enable: rdata captures the line at index
//   index in  line index
//   wdata in  write line
//   rdata out registered read line; holds when re is low
// Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_line_array #(
  parameter int LINES = 4096,
  parameter int IDX_W = 12
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [IDX_W-1:0]   index,
  input  logic [127:0]       wdata,
  output logic [127:0]       rdata
);

  logic [127:0] r_mem [LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[index] <= wdata;
    end
    if (re) begin
      rdata <= r_mem[index];
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : l2_pmem_responder
// Description : Physical-memory model behind the L2. Arbitrates demand over
//               prefetch, serialises accesses, waits LATENCY cycles per
//               access and returns 128-bit lines with one-cycle resp pulses.
//   clk     in  clock
//   reset_n in  asynchronous active-low reset
//   bus     slave modport of l2_pmem_responder_if
// Revision    : 1.0 - initial release
// ============================================================================
module l2_pmem_responder
  import l2_pmem_responder_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int LINES   = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  l2_pmem_responder_if.slave bus
);

  localparam int         IDX_W        = $clog2(LINES);
  localparam logic [7:0] C_COUNT_INIT = 8'(LATENCY - 1);

  lc3b_pmem_state_t r_state;
  lc3b_pmem_state_t w_next_state;
  logic [7:0]       r_count;
  logic [IDX_W-1:0] r_d_index;
  logic [IDX_W-1:0] r_n_index;
  logic [IDX_W-1:0] w_mem_index;
  logic             r_is_write;
  lc3b_data         r_wdata;
  lc3b_data         r_rdata;
  lc3b_data         r_n_rdata;
  lc3b_data         w_mem_rdata;
  logic             w_mem_we;
  logic             w_mem_re;

  // Byte-offset bits carry no meaning for a line-granular store.
  logic w_unused_offset_bits;
  assign w_unused_offset_bits = ^{bus.pmem_address[LC3B_LINE_OFFSET_BITS-1:0],
                                  bus.pmem_n_address[LC3B_LINE_OFFSET_BITS-1:0]};

  pmem_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_line_array (
    .clk   (clk),
    .we    (w_mem_we),
    .re    (w_mem_re),
    .index (w_mem_index),
    .wdata (r_wdata),
    .rdata (w_mem_rdata)
  );

  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    w_mem_index  = (r_state == S_PREFETCH) ? r_n_index : r_d_index;
    case (r_state)
      S_IDLE: begin
        if (bus.pmem_read || bus.pmem_write) begin
          w_next_state = S_DEMAND;
        end else if (bus.pmem_n_read) begin
          w_next_state = S_PREFETCH;
        end
      end
      S_DEMAND: begin
        if (r_count == 8'd0) begin
          w_mem_we     = r_is_write;
          w_mem_re     = !r_is_write;
          w_next_state = S_DRESP;
        end
      end
      S_PREFETCH: begin
        if (r_count == 8'd0) begin
          w_mem_re     = 1'b1;
          w_next_state = S_NRESP;
        end
      end
      default: w_next_state = S_IDLE;  // DRESP/NRESP last exactly one cycle
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_count    <= 8'd0;
      r_d_index  <= '0;
      r_n_index  <= '0;
      r_is_write <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_n_rdata  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (bus.pmem_read || bus.pmem_write) begin
            r_d_index  <= bus.pmem_address[LC3B_LINE_OFFSET_BITS +: IDX_W];
            r_is_write <= bus.pmem_write;  // write wins if both are raised
            r_wdata    <= bus.pmem_wdata;
            r_count    <= C_COUNT_INIT;
          end else if (bus.pmem_n_read) begin
            r_n_index  <= bus.pmem_n_address[LC3B_LINE_OFFSET_BITS +: IDX_W];
            r_count    <= C_COUNT_INIT;
          end
        end
        S_DEMAND, S_PREFETCH: begin
          if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
          end
        end
        // Capture the freshly read line so the port keeps presenting it
        // after the resp cycle.
        S_DRESP: begin
          if (!r_is_write) begin
            r_rdata <= w_mem_rdata;
          end
        end
        S_NRESP: r_n_rdata <= w_mem_rdata;
        default: ;
      endcase
    end
  end

  // The store's read register is shared by both ports, so each port shows it
  // only during its own read resp cycle and its private hold copy otherwise.
  assign bus.pmem_resp    = (r_state == S_DRESP);
  assign bus.pmem_n_resp  = (r_state == S_NRESP);
  assign bus.pmem_rdata   = (r_state == S_DRESP && !r_is_write) ? w_mem_rdata : r_rdata;
  assign bus.pmem_n_rdata = (r_state == S_NRESP) ? w_mem_rdata : r_n_rdata;

  a_no_read_with_write: assert property (
    @(posedge clk) disable iff (!reset_n) !(bus.pmem_read && bus.pmem_write)
  );

endmodule
`default_nettype wire

// File: tb/tb_l2_pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_pmem_responder
// Description : Scoreboard bench for l2_pmem_responder. Two instances: one
//               with LATENCY=8 and one with LATENCY=1. Expected responses
//               (line and arrival cycle) are queued when requests are raised;
//               a negedge monitor pops and compares on every resp pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_pmem_responder;

  typedef struct {
    logic [127:0] data;
    bit           chk;
    int           cyc;
  } exp_t;

  localparam logic [127:0] D1 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] D2 = 128'h01240124_A5A5A5A5_5A5A5A5A_0000FFFF;
  localparam logic [127:0] D3 = 128'h00100010_11111111_22222222_33333333;
  localparam logic [127:0] D4 = 128'h00200020_44444444_55555555_66666666;
  localparam logic [127:0] D5 = 128'h05000500_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] D6 = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBAD00;
  localparam logic [127:0] D7 = 128'hFFF0FFF0_0F0F0F0F_F0F0F0F0_77777777;
  localparam logic [127:0] D8 = 128'h00000000_89898989_13579BDF_2468ACE0;

  logic clk = 1'b0;
  logic rst8_n = 1'b0;
  logic rst1_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q [4][$];   // 0: demand L8, 1: prefetch L8, 2: demand L1, 3: prefetch L1

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_pmem_responder_if b8 ();
  l2_pmem_responder_if b1 ();

  l2_pmem_responder #(.LATENCY(8), .LINES(4096)) u_dut8 (
    .clk(clk), .reset_n(rst8_n), .bus(b8)
  );
  l2_pmem_responder #(.LATENCY(1), .LINES(4096)) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(b1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_dmd(input int d, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [127:0] wd);
    if (d == 0) begin
      b8.pmem_read = rd; b8.pmem_write = wr; b8.pmem_address = a; b8.pmem_wdata = wd;
    end else begin
      b1.pmem_read = rd; b1.pmem_write = wr; b1.pmem_address = a; b1.pmem_wdata = wd;
    end
  endtask

  task automatic set_pf(input int d, input bit rd, input logic [15:0] a);
    if (d == 0) begin
      b8.pmem_n_read = rd; b8.pmem_n_address = a;
    end else begin
      b1.pmem_n_read = rd; b1.pmem_n_address = a;
    end
  endtask

  function automatic logic get_resp(input int p);
    case (p)
      0:       return b8.pmem_resp;
      1:       return b8.pmem_n_resp;
      2:       return b1.pmem_resp;
      default: return b1.pmem_n_resp;
    endcase
  endfunction

  task automatic push(input int p, input logic [127:0] data, input bit c, input int at);
    exp_t e;
    e.data = data;
    e.chk  = c;
    e.cyc  = at;
    q[p].push_back(e);
  endtask

  // Wait (bounded) for the resp of port p, then return #1 after the following
  // edge, which is where the requester drops its request.
  task automatic wait_resp(input int p);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = get_resp(p);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout port%0d: got no resp, expected one within 64 cycles", p);
    end
    @(posedge clk);
    #1;
  endtask

  // Single demand access on an idle DUT: accepted at the next edge, resp
  // LATENCY edges after that.
  task automatic dmd_op(input int d, input bit wr, input logic [15:0] a,
                        input logic [127:0] wd, input logic [127:0] exp_rd, input int lat);
    set_dmd(d, !wr, wr, a, wd);
    push(d * 2, exp_rd, !wr, cyc + 1 + lat);
    wait_resp(d * 2);
    set_dmd(d, 1'b0, 1'b0, 16'h0000, '0);
  endtask

  task automatic pf_op(input int d, input logic [15:0] a, input logic [127:0] exp_rd, input int lat);
    set_pf(d, 1'b1, a);
    push(d * 2 + 1, exp_rd, 1'b1, cyc + 1 + lat);
    wait_resp(d * 2 + 1);
    set_pf(d, 1'b0, 16'h0000);
  endtask

  task automatic mon(input int p, input logic resp, input logic [127:0] data);
    exp_t e;
    if (resp) begin
      n_cmp++;
      if (q[p].size() == 0) begin
        n_fail++;
        $display("FAIL port%0d unexpected resp: got resp at cycle %0d, expected none", p, cyc);
      end else begin
        e = q[p].pop_front();
        if (cyc != e.cyc || (e.chk && data !== e.data)) begin
          n_fail++;
          $display("FAIL port%0d resp: got cycle %0d data %h, expected cycle %0d data %h",
                   p, cyc, data, e.cyc, e.data);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b8.pmem_resp,   b8.pmem_rdata);
    mon(1, b8.pmem_n_resp, b8.pmem_n_rdata);
    mon(2, b1.pmem_resp,   b1.pmem_rdata);
    mon(3, b1.pmem_n_resp, b1.pmem_n_rdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    set_dmd(0, 1'b0, 1'b0, 16'h0000, '0);
    set_dmd(1, 1'b0, 1'b0, 16'h0000, '0);
    set_pf(0, 1'b0, 16'h0000);
    set_pf(1, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset resp",     {127'd0, b8.pmem_resp},   '0);
    chk("reset n_resp",   {127'd0, b8.pmem_n_resp}, '0);
    chk("reset rdata",    b8.pmem_rdata,            '0);
    chk("reset n_rdata",  b8.pmem_n_rdata,          '0);
    rst8_n = 1'b1;
    rst1_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read back the same line through a different byte offset.
    dmd_op(0, 1'b1, 16'h1230, D1, '0, 8);
    dmd_op(0, 1'b0, 16'h123F, '0, D1, 8);

    // Prefetch of a freshly written line; demand port must stay silent.
    dmd_op(0, 1'b1, 16'h1240, D2, '0, 8);
    pf_op(0, 16'h1240, D2, 8);

    // Simultaneous demand and prefetch: demand first, prefetch after.
    dmd_op(0, 1'b1, 16'h0010, D3, '0, 8);
    dmd_op(0, 1'b1, 16'h0020, D4, '0, 8);
    c = cyc;
    set_dmd(0, 1'b1, 1'b0, 16'h0010, '0);
    set_pf(0, 1'b1, 16'h0020);
    push(0, D3, 1'b1, c + 9);
    push(1, D4, 1'b1, c + 19);
    wait_resp(0);
    set_dmd(0, 1'b0, 1'b0, 16'h0000, '0);
    wait_resp(1);
    set_pf(0, 1'b0, 16'h0000);

    // Non-preemption: demand raised 3 cycles into a prefetch waits for it.
    c = cyc;
    set_pf(0, 1'b1, 16'h0020);
    push(1, D4, 1'b1, c + 9);
    repeat (3) @(posedge clk);
    #1;
    set_dmd(0, 1'b1, 1'b0, 16'h123F, '0);
    push(0, D1, 1'b1, c + 19);
    wait_resp(1);
    set_pf(0, 1'b0, 16'h0000);
    wait_resp(0);
    set_dmd(0, 1'b0, 1'b0, 16'h0000, '0);

    // Reset while a write is in flight (counter at 2): aborted, no resp.
    dmd_op(0, 1'b1, 16'h0500, D5, '0, 8);
    set_dmd(0, 1'b0, 1'b1, 16'h0500, D6);
    repeat (6) @(posedge clk);
    #1;
    rst8_n = 1'b0;
    #1;
    chk("midrst resp",    {127'd0, b8.pmem_resp},   '0);
    chk("midrst n_resp",  {127'd0, b8.pmem_n_resp}, '0);
    chk("midrst rdata",   b8.pmem_rdata,            '0);
    chk("midrst n_rdata", b8.pmem_n_rdata,          '0);
    set_dmd(0, 1'b0, 1'b0, 16'h0000, '0);
    repeat (2) @(posedge clk);
    #1;
    rst8_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    dmd_op(0, 1'b0, 16'h0500, '0, D5, 8);

    // LATENCY=1: top line and line 0 must not alias; back-to-back reads.
    dmd_op(1, 1'b1, 16'hFFF0, D7, '0, 1);
    dmd_op(1, 1'b1, 16'h0000, D8, '0, 1);
    dmd_op(1, 1'b0, 16'hFFF0, '0, D7, 1);
    dmd_op(1, 1'b0, 16'h0000, '0, D8, 1);

    repeat (5) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (q[p].size() != 0) begin
        n_fail++;
        $display("FAIL port%0d pending: got %0d responses outstanding, expected 0", p, q[p].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
